// File: rtl/decompressor_controller.sv
// Drains a FWFT decompressor FIFO into a one-entry registered AXI-Stream master, tagging header/flag per beat.
// Latency 1 cycle FIFO head to m_tdata; pops only when the output register is empty or being accepted.
module decompressor_controller #(
  parameter int BURST_WIDTH = 256,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BURST_WIDTH-1:0] fifo_dout,
  input  logic                   fifo_last,
  input  logic                   fifo_empty,
  output logic                   fifo_pop,
  output logic [BURST_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [2:0]             state,
  output logic                   is_header,
  output logic                   flag_decompression,
  output logic [CNT_WIDTH-1:0]   data_beats,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic                   runt_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H0   = 3'd1,
    S_H1   = 3'd2,
    S_H2   = 3'd3,
    S_H3   = 3'd4,
    S_DATA = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_pop;
  logic                   w_hdr_tag;
  logic                   w_flag_hit;
  logic                   w_flag_tag;
  logic                   w_runt;

  logic [BURST_WIDTH-1:0] r_tdata;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic                   r_is_header;
  logic                   r_flag_out;
  logic                   r_pkt_flag;
  logic [CNT_WIDTH-1:0]   r_data_beats;
  logic [CNT_WIDTH-1:0]   r_pkt_count;
  logic                   r_runt_err;

  assign w_pop = !fifo_empty && (!r_tvalid || m_tready);

  // Marked TCP packet: ethertype/length word, protocol and header-length fields of the first beat.
  assign w_flag_hit = (fifo_dout[111:96] == 16'h0008) &&
                      (fifo_dout[191:184] == 8'h06) &&
                      (fifo_dout[127:120] == 8'h28);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_pop) begin
      if (fifo_last) begin
        w_next_state = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  w_next_state = S_H0;
          S_H0:    w_next_state = S_H1;
          S_H1:    w_next_state = S_H2;
          S_H2:    w_next_state = S_H3;
          S_H3:    w_next_state = S_DATA;
          S_DATA:  w_next_state = S_DATA;
          default: w_next_state = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_hdr_tag  = (r_state == S_IDLE) || (r_state == S_H0) ||
                 (r_state == S_H1)   || (r_state == S_H2);
    w_flag_tag = (r_state == S_IDLE) ? w_flag_hit : r_pkt_flag;
    w_runt     = w_pop && fifo_last && (r_state != S_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_is_header  <= 1'b0;
      r_flag_out   <= 1'b0;
      r_pkt_flag   <= 1'b0;
      r_data_beats <= '0;
      r_pkt_count  <= '0;
      r_runt_err   <= 1'b0;
    end else begin
      r_runt_err <= w_runt;
      if (w_pop) begin
        r_tdata     <= fifo_dout;
        r_tlast     <= fifo_last;
        r_is_header <= w_hdr_tag;
        r_flag_out  <= w_flag_tag;
        r_tvalid    <= 1'b1;
        if (fifo_last) begin
          r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
        end
        if (r_state == S_IDLE) begin
          r_pkt_flag   <= w_flag_hit;
          r_data_beats <= '0;
        end else if ((r_state == S_DATA) && (r_data_beats != '1)) begin
          r_data_beats <= r_data_beats + CNT_WIDTH'(1);
        end
      end else if (m_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign fifo_pop           = w_pop;
  assign m_tdata            = r_tdata;
  assign m_tvalid           = r_tvalid;
  assign m_tlast            = r_tlast;
  assign state              = r_state;
  assign is_header          = r_is_header;
  assign flag_decompression = r_flag_out;
  assign data_beats         = r_data_beats;
  assign pkt_count          = r_pkt_count;
  assign runt_err           = r_runt_err;

endmodule

// File: tb/tb_decompressor_controller.sv
// Randomized bench for decompressor_controller: FWFT FIFO model feeding the DUT, packet-position reference model.
module tb_decompressor_controller;

  typedef struct {
    logic [255:0] d;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] fifo_dout;
  logic         fifo_last;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [255:0] m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic [2:0]   state;
  logic         is_header;
  logic         flag_decompression;
  logic [15:0]  data_beats;
  logic [15:0]  pkt_count;
  logic         runt_err;

  decompressor_controller #(.BURST_WIDTH(256), .CNT_WIDTH(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .fifo_dout          (fifo_dout),
    .fifo_last          (fifo_last),
    .fifo_empty         (fifo_empty),
    .fifo_pop           (fifo_pop),
    .m_tdata            (m_tdata),
    .m_tvalid           (m_tvalid),
    .m_tlast            (m_tlast),
    .m_tready           (m_tready),
    .state              (state),
    .is_header          (is_header),
    .flag_decompression (flag_decompression),
    .data_beats         (data_beats),
    .pkt_count          (pkt_count),
    .runt_err           (runt_err)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;

  beat_t q[$];
  int    pos;
  bit    pkt_flag;
  int    dbeats;
  int    pkts;
  bit    exp_runt;
  bit    exp_vld;
  beat_t exp_beat;
  bit    exp_hdr;
  bit    exp_flag;
  int    ready_mode;
  int    bubble_mode;
  int    phase_cyc;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [255:0] rnd_beat();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic bit marked(input logic [255:0] d);
    return d[111:96] == 16'h0008 && d[191:184] == 8'h06 && d[127:120] == 8'h28;
  endfunction

  task automatic push_pkt(input int n, input logic [2:0] mark);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = rnd_beat();
      b.l = (i == n - 1);
      if (i == 0) begin
        b.d[111:96]  = mark[0] ? 16'h0008 : 16'h1234;
        b.d[191:184] = mark[1] ? 8'h06 : 8'h11;
        b.d[127:120] = mark[2] ? 8'h28 : 8'h00;
      end
      q.push_back(b);
    end
  endtask

  task automatic do_cycle();
    bit    gate;
    bit    pop_exp;
    beat_t b;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = !(phase_cyc >= 7 && phase_cyc <= 9);
    endcase
    case (bubble_mode)
      0:       gate = 1'b0;
      1:       gate = (phase_cyc % 2) == 1;
      default: gate = ($urandom_range(0, 3) == 0);
    endcase
    if (q.size() == 0 || gate) begin
      fifo_empty = 1'b1;
      fifo_dout  = rnd_beat();
      fifo_last  = 1'($urandom_range(0, 1));
    end else begin
      fifo_empty = 1'b0;
      fifo_dout  = q[0].d;
      fifo_last  = q[0].l;
    end
    #1;
    check("m_tvalid", m_tvalid, exp_vld);
    if (exp_vld) begin
      check("m_tdata", m_tdata, exp_beat.d);
      check("m_tlast", m_tlast, exp_beat.l);
      check("is_header", is_header, exp_hdr);
      check("flag", flag_decompression, exp_flag);
    end
    pop_exp = !fifo_empty && (!exp_vld || m_tready);
    check("fifo_pop", fifo_pop, pop_exp);
    exp_runt = 1'b0;
    if (pop_exp) begin
      b = q.pop_front();
      exp_hdr = (pos < 4);
      if (pos == 0) begin
        pkt_flag = marked(b.d);
        dbeats   = 0;
      end
      if (pos >= 5 && dbeats < 65535) dbeats++;
      exp_runt = b.l && (pos < 5);
      if (b.l) begin
        pkts = (pkts + 1) % 65536;
        pos  = 0;
      end else begin
        pos = (pos < 5) ? pos + 1 : 5;
      end
      exp_flag = pkt_flag;
      exp_beat = b;
      exp_vld  = 1'b1;
    end else if (m_tready) begin
      exp_vld = 1'b0;
    end
    phase_cyc++;
    @(posedge clk);
    #1;
    check("runt_err", runt_err, exp_runt);
    check("state", state, pos);
    check("data_beats", data_beats, dbeats);
    check("pkt_count", pkt_count, pkts);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    fifo_empty = 1'b1;
    fifo_last  = 1'b0;
    fifo_dout  = rnd_beat();
    m_tready   = 1'b1;
    @(posedge clk);
    #1;
    pos = 0; pkt_flag = 0; dbeats = 0; pkts = 0; exp_runt = 0; exp_vld = 0;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_hdr", is_header, 0);
    check("rst_flag", flag_decompression, 0);
    check("rst_state", state, 0);
    check("rst_dbeats", data_beats, 0);
    check("rst_pkts", pkt_count, 0);
    check("rst_runt", runt_err, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_drain(input int budget);
    int c = 0;
    phase_cyc = 0;
    while ((q.size() > 0 || exp_vld) && c < budget) begin
      do_cycle();
      c++;
    end
    check("drain_budget", c < budget, 1);
    do_cycle();
    do_cycle();
  endtask

  initial begin
    reset = 1'b1; fifo_empty = 1'b1; fifo_last = 1'b0; fifo_dout = '0; m_tready = 1'b1;
    ready_mode = 0; bubble_mode = 0; phase_cyc = 0;
    @(negedge clk);
    do_reset();

    push_pkt(7, 3'b111);              // marked seven-beat packet
    run_drain(100);
    push_pkt(7, 3'b011);              // unmarked: protocol header-length byte cleared
    run_drain(100);

    ready_mode = 2;                   // three-cycle stall mid-DATA
    push_pkt(12, 3'b111);
    run_drain(100);
    ready_mode = 0;

    push_pkt(3, 3'b111);              // runt ending on the H1 beat
    push_pkt(7, 3'b111);
    run_drain(100);
    push_pkt(1, 3'b000);              // single-beat runt
    run_drain(100);

    bubble_mode = 1;
    push_pkt(9, 3'b111);
    push_pkt(6, 3'b101);
    run_drain(200);
    bubble_mode = 0;

    push_pkt(8, 3'b111);              // reset after the H2 beat
    phase_cyc = 0;
    for (int i = 0; i < 20 && pos < 3; i++) do_cycle();
    check("pre_reset_pos", pos, 3);
    do_reset();
    run_drain(100);

    ready_mode = 1; bubble_mode = 2;
    for (int p = 0; p < 30; p++) begin
      push_pkt($urandom_range(1, 12), ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7)));
    end
    run_drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decompressor_controller.md
Name: decompressor_controller

Overview:
- Receive-side controller for the decompression path. It drains packet beats from the decompressor output FIFO, which is first-word-fall-through, and presents them to the downstream consumer as an AXI-Stream master through a one-entry registered output stage.
- It tracks the header and data framing of each packet with the same beat structure used on the compress side: 4 header beats, 1 non-header beat, then data.
- It latches a per-packet flag_decompression and a per-beat is_header so the decompression engine can tell marked TCP packets and header beats apart.

Parameters:
BURST_WIDTH, 256, beat width in bits; field offsets below assume 256.
CNT_WIDTH, 16, width of the data-beat counter and the packet counter.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
fifo_dout  input  BURST_WIDTH  FWFT FIFO head data; valid while fifo_empty=0.
fifo_last  input  1  last-beat marker stored alongside fifo_dout.
fifo_empty  input  1  FIFO empty.
fifo_pop  output  1  combinational pop of the FIFO head.
m_tdata  output  BURST_WIDTH  registered output beat.
m_tvalid  output  1  output beat valid.
m_tlast  output  1  output beat is last of packet.
m_tready  input  1  downstream accept.
state  output  3  FSM state: IDLE=0, H0=1, H1=2, H2=3, H3=4, DATA=5.
is_header  output  1  registered; high with m_tvalid when the current output beat is a header beat.
flag_decompression  output  1  registered; constant for all beats of a packet.
data_beats  output  CNT_WIDTH  count of DATA-state beats in the current or last packet.
pkt_count  output  CNT_WIDTH  completed packets; wraps at 2^CNT_WIDTH.
runt_err  output  1  one-cycle pulse when a packet ends before DATA.

Behaviour:
- Reset (synchronous, active-high, overrides everything): state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, is_header=0, flag_decompression=0, data_beats=0, pkt_count=0, runt_err=0.
- Reset mid-packet abandons the packet. The FIFO is not flushed, and the next popped beat is treated as a first beat.
- Output stage:
  - fifo_pop = !fifo_empty && (!m_tvalid || m_tready).
  - On fifo_pop, the output register loads fifo_dout and fifo_last, the tagged is_header and flag_decompression, and sets m_tvalid=1.
  - If m_tvalid && m_tready && !fifo_pop, then m_tvalid goes to 0.
  - Latency from FIFO head to m_tdata is 1 cycle. Full throughput is 1 beat/cycle while m_tready=1.
  - m_tdata, m_tlast and the tags are held stable while m_tvalid && !m_tready.
- The FSM advances only on fifo_pop:
  - IDLE→H0, H0→H1, H1→H2, H2→H3, H3→DATA.
  - DATA→IDLE when fifo_last=1.
  - No pop means no state change.
- is_header tag is 1 for beats popped in IDLE, H0, H1 and H2, and 0 for the H3 beat and all DATA beats.
- flag_decompression:
  - Evaluated on the beat popped in IDLE as fifo_dout[111:96]==16'h0008 && fifo_dout[191:184]==8'h06 && fifo_dout[127:120]==8'h28.
  - Held in a packet register and applied to every beat of the packet, including the first.
  - Cleared to 0 on the IDLE pop if the condition is false.
- Runt packet (fifo_last=1 on a pop in IDLE..H3):
  - FSM goes to IDLE.
  - runt_err pulses for 1 cycle, the cycle after the pop.
  - The beat is still forwarded with m_tlast=1.
  - pkt_count still increments.
- data_beats:
  - Cleared on the IDLE pop.
  - +1 on each DATA-state pop, including the last.
  - Saturates at all-ones and holds its value after the packet.
- pkt_count: +1 on every pop with fifo_last=1; wraps from all-ones to 0.
- Simultaneous events:
  - Pop and output drain in the same cycle: the register reloads and m_tvalid stays 1.
  - fifo_empty=1 while m_tready=1: the output drains and the FSM holds.

Test Plan:
- Seven-beat packet after reset:
  - Stimulus: beat0 with [111:96]=0x0008, [191:184]=0x06, [127:120]=0x28; beat6 with last=1; m_tready=1.
  - Response: m_tvalid on 7 consecutive cycles starting 1 cycle after the first pop; is_header=1,1,1,1,0,0,0; flag_decompression=1 on all 7 beats; m_tlast only on beat6; data_beats=2; pkt_count=1; state back to 0.
- Unmarked packet:
  - Stimulus: same packet with [127:120]=0x00.
  - Response: flag_decompression=0 on all beats; framing identical to the previous scenario.
- Backpressure:
  - Stimulus: m_tready=0 for 3 cycles mid-DATA.
  - Response: fifo_pop=0 during the stall; m_tdata held; no beat lost or duplicated; state constant.
- Runt packet:
  - Stimulus: 3-beat packet with last on the beat popped in H1.
  - Response: beat forwarded with m_tlast=1; runt_err pulses once; next packet's first beat gets is_header=1 and a fresh flag evaluation.
- FIFO bubbles:
  - Stimulus: fifo_empty toggling every other cycle.
  - Response: FSM advances only on pops; output order and tags are correct.
- Reset mid-packet:
  - Stimulus: reset after the H2 beat.
  - Response: m_tvalid=0, state=0, counters=0; the next popped beat is treated as header beat 0.
